rx_uart: RTL
============

// Module: rx_uart
// PURPOSE
//   UART receiver for the same 8N1 link the TxUART transmitter drives: 1 start bit,
//   8 data bits LSB first, 1 stop bit, idle line high.
//   Sits between the external serial input pin and the receive FIFO.
//   Synchronises the line, detects and validates the start bit, samples each bit at
//   mid-bit, then writes each good byte into the RX FIFO.
//   Flags framing errors and bytes lost to a full FIFO.
// PARAMETERS
//   cbaudCnt   108  clock cycles per bit period; legal range 4..1023 (10-bit counter)
//   cSyncStg   2    synchroniser flip-flop stages on SerialDataIn; legal range 2..3
// PORTS
//   Clk            in   1  system clock; the only clock
//   RstB           in   1  asynchronous reset, active-low
//   SerialDataIn   in   1  asynchronous serial line input; idle high
//   RxFfFull       in   1  RX FIFO full flag
//   RxFfWrEn       out  1  RX FIFO write strobe; one-cycle pulse
//   RxFfWrData     out  8  received byte; valid while RxFfWrEn=1
//   RxFrameErr     out  1  one-cycle pulse: stop bit sampled low
//   RxOverrun      out  1  one-cycle pulse: good byte dropped because RxFfFull=1
// BEHAVIOUR
// - Reset (RstB=0, async): state=stIdle.
//   - Synchroniser chain all 1s; baud counter=cbaudCnt; bit counter=0.
//   - RxFfWrEn=0, RxFfWrData=8'h00, RxFrameErr=0, RxOverrun=0.
//   - Reset mid-frame abandons the frame; no write, no flag.
// - All outputs are registered. SerialDataIn is used only after the cSyncStg-stage
//   synchroniser; "line" below means the synchronised signal.
// - Timing reference: cycle 0 = first Clk cycle in stIdle at which line=0.
//   HALF = cbaudCnt/2, truncated.
//   - start check at cycle HALF
//   - data bit k (k=0..7) sampled at HALF + (k+1)*cbaudCnt
//   - stop bit sampled at HALF + 9*cbaudCnt
// - State machine:
//   - stIdle:   line=0 -> stStart; load baud counter with HALF.
//   - stStart:  count down. At the tick (counter==1), reload cbaudCnt.
//     - line=0 -> stData, bit counter=0
//     - line=1 -> stIdle (glitch rejected; no flag)
//   - stData:   at each tick, shift line into the MSB of the shift register
//     (LSB-first assembly) and increment the bit counter. After the 8th bit -> stStop.
//   - stStop:   at the tick, sample line:
//     - line=1, RxFfFull=0 -> next cycle RxFfWrEn=1 with RxFfWrData=byte; -> stIdle
//     - line=1, RxFfFull=1 -> next cycle RxOverrun=1; byte dropped; -> stIdle
//     - line=0             -> next cycle RxFrameErr=1; no write; -> stWtIdle
//   - stWtIdle: stay until line=1, then -> stIdle (break / stuck-low line does not
//     retrigger a frame).
// - Latency: RxFfWrEn rises at cycle HALF + 9*cbaudCnt + 1, i.e. 1027 with defaults,
//   plus cSyncStg cycles measured from the SerialDataIn pin edge.
// - RxFfFull is sampled only on the stop-bit tick cycle.
// - Back-to-back frames: a start edge may be detected on the cycle after the return
//   to stIdle; no extra idle bit is required beyond the stop bit's second half.
// - RxFfWrEn, RxFrameErr and RxOverrun are mutually exclusive; each is high for
//   exactly one cycle per frame at most.
// - RxFfWrData holds its last value between writes.
// - Illegal state encodings -> stIdle on the next clock.
// TESTING
// 1. Byte 8'hA5 at the default rate, RxFfFull=0
//    -> exactly one RxFfWrEn pulse, RxFfWrData=8'hA5 at cycle 1027 after the
//       synchronised falling edge; no flags.
// 2. Bytes 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap
//    -> three writes in order, spaced exactly 10*cbaudCnt = 1080 cycles apart.
// 3. Line pulled low for 20 cycles, then high (glitch)
//    -> returns to stIdle at the start check; no RxFfWrEn, RxFrameErr or RxOverrun.
// 4. Frame 8'h3C with stop bit driven 0, then line held low for 2000 cycles
//    -> one RxFrameErr pulse; no write.
//    Then release high and send 8'h81 -> one write of 8'h81.
// 5. RxFfFull=1 during the frame for 8'h7E
//    -> one RxOverrun pulse, no RxFfWrEn.
//    Deassert full and send 8'h7E again -> write 8'h7E.
// 6. RstB pulsed low mid-frame for 8'hC3, then a full frame of 8'h12
//    -> outputs zero during reset; no write of 8'hC3; one write of 8'h12.
//    Repeat test 1 with cbaudCnt=16 -> write at cycle 8+144+1=153.

Source files
------------

// File: rtl/rx_uart_if.sv
// Receive-side signal bundle for rx_uart: serial line in, FIFO write side out,
// plus the framing-error and overrun pulses.
interface rx_uart_if;
    logic       SerialDataIn;
    logic       RxFfFull;
    logic       RxFfWrEn;
    logic [7:0] RxFfWrData;
    logic       RxFrameErr;
    logic       RxOverrun;

    // Receiver side: consumes the line and FIFO status, produces writes and flags
    modport master (
        input  SerialDataIn,
        input  RxFfFull,
        output RxFfWrEn,
        output RxFfWrData,
        output RxFrameErr,
        output RxOverrun
    );

    // Environment side: drives the line and FIFO status, observes writes and flags
    modport slave (
        output SerialDataIn,
        output RxFfFull,
        input  RxFfWrEn,
        input  RxFfWrData,
        input  RxFrameErr,
        input  RxOverrun
    );
endinterface

// File: rtl/rx_uart.sv
// 8N1 UART receiver: synchronises the serial line, validates the start bit at
// mid-bit, samples 8 data bits LSB first, checks the stop bit, then writes the
// byte to the RX FIFO or flags a framing error / overrun.
module rx_uart #(
    parameter int cbaudCnt = 108,
    parameter int cSyncStg = 2
) (
    input  logic     Clk,
    input  logic     RstB,
    rx_uart_if.master bus
);

    localparam logic [9:0] cBaud = 10'(cbaudCnt);
    localparam logic [9:0] cHalf = 10'(cbaudCnt / 2);

    typedef enum logic [2:0] {
        stIdle   = 3'd0,
        stStart  = 3'd1,
        stData   = 3'd2,
        stStop   = 3'd3,
        stWtIdle = 3'd4
    } state_t;

    state_t              r_state;
    logic [cSyncStg-1:0] r_sync;
    logic [9:0]          r_baud;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_wr_en;
    logic [7:0]          r_wr_data;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_line;
    logic                w_tick;

    assign w_line = r_sync[cSyncStg-1];
    assign w_tick = (r_baud == 10'd1);

    assign bus.RxFfWrEn   = r_wr_en;
    assign bus.RxFfWrData = r_wr_data;
    assign bus.RxFrameErr = r_frame_err;
    assign bus.RxOverrun  = r_overrun;

    // Metastability synchroniser on the asynchronous serial pin; idles high
    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[cSyncStg-2:0], bus.SerialDataIn};
        end
    end

    // Frame state machine with registered one-cycle output pulses
    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            r_state     <= stIdle;
            r_baud      <= cBaud;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            case (r_state)
                stIdle: begin
                    if (!w_line) begin
                        r_state <= stStart;
                        r_baud  <= cHalf;
                    end
                end
                stStart: begin
                    if (w_tick) begin
                        r_baud <= cBaud;
                        if (!w_line) begin
                            r_state   <= stData;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= stIdle;
                        end
                    end else begin
                        r_baud <= r_baud - 10'd1;
                    end
                end
                stData: begin
                    if (w_tick) begin
                        r_baud    <= cBaud;
                        r_shift   <= {w_line, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= stStop;
                        end
                    end else begin
                        r_baud <= r_baud - 10'd1;
                    end
                end
                stStop: begin
                    if (w_tick) begin
                        r_baud <= cBaud;
                        if (w_line) begin
                            r_state <= stIdle;
                            if (bus.RxFfFull) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_data <= r_shift;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= stWtIdle;
                        end
                    end else begin
                        r_baud <= r_baud - 10'd1;
                    end
                end
                stWtIdle: begin
                    if (w_line) begin
                        r_state <= stIdle;
                    end
                end
                default: begin
                    r_state <= stIdle;
                end
            endcase
        end
    end

endmodule
